// File: rtl/traffic_pkg.sv
// traffic_pkg
//    Shared types and helpers for the intersection phase controller.
//    phase_t  : phase codes reported on the controller's phase output
//    sub_t    : LOAD/WAIT sub-state inside a phase (plus the post-reset entry step)
//    bcd2_t   : two-digit BCD value {hi, lo}
//    LT_*     : one-hot light head codes {R,Y,G}
//    bcd2bin  : two BCD digits to binary, any digit above 9 reads as 9
//    bin2bcd  : binary 0..99 to two BCD digits
package traffic_pkg;

   typedef enum logic [2:0] {
      A_GREEN   = 3'd0,
      A_YELLOW  = 3'd1,
      ALL_RED_A = 3'd2,
      B_GREEN   = 3'd3,
      B_YELLOW  = 3'd4,
      ALL_RED_B = 3'd5,
      WALK      = 3'd6
   } phase_t;

   // SUB_ENTER exists only between reset release and the first ALL_RED_B load.
   typedef enum logic [1:0] {
      SUB_ENTER,
      SUB_LOAD,
      SUB_WAIT
   } sub_t;

   typedef struct packed {
      logic [3:0] hi;
      logic [3:0] lo;
   } bcd2_t;

   localparam logic [2:0] LT_RED = 3'b100;
   localparam logic [2:0] LT_YEL = 3'b010;
   localparam logic [2:0] LT_GRN = 3'b001;

   function automatic logic [3:0] digit_sat(input logic [3:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

   function automatic logic [6:0] bcd2bin(input logic [3:0] hi, input logic [3:0] lo);
      logic [6:0] h;
      logic [6:0] l;
      h = {3'b000, digit_sat(hi)};
      l = {3'b000, digit_sat(lo)};
      return h * 7'd10 + l;
   endfunction

   function automatic bcd2_t bin2bcd(input logic [6:0] v);
      bcd2_t r;
      r.hi = 4'(v / 7'd10);
      r.lo = 4'(v % 7'd10);
      return r;
   endfunction

endpackage

// File: rtl/green_calc.sv
// green_calc
//    Combinational green-time sizing for one approach.
//    cnt_hi, cnt_lo : BCD vehicle count (digits above 9 saturate to 9)
//    green          : BCD green time = clamp(count * SCALE, MIN_GREEN, MAX_GREEN)
module green_calc
   import traffic_pkg::*;
#(
   parameter int unsigned SCALE     = 5,
   parameter int unsigned MIN_GREEN = 10,
   parameter int unsigned MAX_GREEN = 90
) (
   input  logic [3:0] cnt_hi,
   input  logic [3:0] cnt_lo,
   output bcd2_t      green
);

   localparam logic [9:0] SCALE10 = 10'(SCALE);
   localparam logic [9:0] MIN10   = 10'(MIN_GREEN);
   localparam logic [9:0] MAX10   = 10'(MAX_GREEN);

   logic [6:0] n;
   logic [9:0] g_raw;
   logic [6:0] g;

   always_comb begin
      n     = bcd2bin(cnt_hi, cnt_lo);
      // 10-bit product so 99 * SCALE does not wrap before clamping
      g_raw = {3'b000, n} * SCALE10;
      if (g_raw < MIN10) begin
         g = 7'(MIN_GREEN);
      end else if (g_raw > MAX10) begin
         g = 7'(MAX_GREEN);
      end else begin
         g = g_raw[6:0];
      end
      green = bin2bcd(g);
   end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl
//    Two-approach intersection sequencer: A green/yellow/all-red, then B, repeating.
//    Each phase loads the shared BCD countdown timer for one cycle, then waits
//    for the timer to report zero before moving on.
//    clock               system clock
//    rst_n               asynchronous active-low reset
//    cnt_a_hi/lo         approach A BCD vehicle count
//    cnt_b_hi/lo         approach B BCD vehicle count
//    tmr_zero            countdown timer reads 00
//    tmr_load            one-cycle timer load strobe
//    tmr_hi/lo           BCD load value, held outside the load cycle
//    light_a/light_b     one-hot light heads {R,Y,G}
//    dir                 0 = A owns right of way, 1 = B
//    phase               current phase (traffic_pkg::phase_t)
//    ped_req, walk       pedestrian request / walk lamp, only with TPC_PED_WALK_EN
//    Optional feature macro: TPC_PED_WALK_EN (inserts a WALK phase after an
//    all-red when a pedestrian request is latched).
module traffic_phase_ctrl
   import traffic_pkg::*;
#(
   parameter int unsigned SCALE     = 5,
   parameter int unsigned MIN_GREEN = 10,
   parameter int unsigned MAX_GREEN = 90,
   parameter int unsigned YELLOW_T  = 3,
   parameter int unsigned ALLRED_T  = 2,
   parameter int unsigned WALK_T    = 15
) (
   input  logic       clock,
   input  logic       rst_n,
   input  logic [3:0] cnt_a_hi,
   input  logic [3:0] cnt_a_lo,
   input  logic [3:0] cnt_b_hi,
   input  logic [3:0] cnt_b_lo,
   input  logic       tmr_zero,
   output logic       tmr_load,
   output logic [3:0] tmr_hi,
   output logic [3:0] tmr_lo,
   output logic [2:0] light_a,
   output logic [2:0] light_b,
   output logic       dir,
   output phase_t     phase
`ifdef TPC_PED_WALK_EN
   ,
   input  logic       ped_req,
   output logic       walk
`endif
);

   localparam bcd2_t YEL_BCD    = bin2bcd(7'(YELLOW_T));
   localparam bcd2_t ALLRED_BCD = bin2bcd(7'(ALLRED_T));
   localparam bcd2_t WALK_BCD   = bin2bcd(7'(WALK_T));

   sub_t       sub;
   phase_t     nxt_phase;
   bcd2_t      nxt_dur;
   bcd2_t      green_a;
   bcd2_t      green_b;
   logic [2:0] nxt_la;
   logic [2:0] nxt_lb;
   logic       nxt_dir;
   logic       ped_pending;

   green_calc #(
      .SCALE     (SCALE),
      .MIN_GREEN (MIN_GREEN),
      .MAX_GREEN (MAX_GREEN)
   ) u_green_a (
      .cnt_hi (cnt_a_hi),
      .cnt_lo (cnt_a_lo),
      .green  (green_a)
   );

   green_calc #(
      .SCALE     (SCALE),
      .MIN_GREEN (MIN_GREEN),
      .MAX_GREEN (MAX_GREEN)
   ) u_green_b (
      .cnt_hi (cnt_b_hi),
      .cnt_lo (cnt_b_lo),
      .green  (green_b)
   );

`ifdef TPC_PED_WALK_EN
   logic ped_latch;
   assign ped_pending = ped_latch;
`else
   assign ped_pending = 1'b0;
`endif

   // Successor of the current phase when its timer expires.
   always_comb begin
      nxt_phase = ALL_RED_B;
      case (phase)
         A_GREEN:   nxt_phase = A_YELLOW;
         A_YELLOW:  nxt_phase = ALL_RED_A;
         ALL_RED_A: nxt_phase = ped_pending ? WALK : B_GREEN;
         B_GREEN:   nxt_phase = B_YELLOW;
         B_YELLOW:  nxt_phase = ALL_RED_B;
         ALL_RED_B: nxt_phase = ped_pending ? WALK : A_GREEN;
         // dir still names the approach that just cleared, so the other one goes next
         WALK:      nxt_phase = dir ? A_GREEN : B_GREEN;
         default:   nxt_phase = ALL_RED_B;
      endcase
   end

   // Duration, lights and right-of-way for the phase being entered.
   always_comb begin
      nxt_dur = ALLRED_BCD;
      nxt_la  = LT_RED;
      nxt_lb  = LT_RED;
      nxt_dir = dir;
      case (nxt_phase)
         A_GREEN: begin
            nxt_dur = green_a;
            nxt_la  = LT_GRN;
            nxt_dir = 1'b0;
         end
         A_YELLOW: begin
            nxt_dur = YEL_BCD;
            nxt_la  = LT_YEL;
            nxt_dir = 1'b0;
         end
         ALL_RED_A: begin
            nxt_dur = ALLRED_BCD;
            nxt_dir = 1'b0;
         end
         B_GREEN: begin
            nxt_dur = green_b;
            nxt_lb  = LT_GRN;
            nxt_dir = 1'b1;
         end
         B_YELLOW: begin
            nxt_dur = YEL_BCD;
            nxt_lb  = LT_YEL;
            nxt_dir = 1'b1;
         end
         ALL_RED_B: begin
            nxt_dur = ALLRED_BCD;
            nxt_dir = 1'b1;
         end
         WALK: begin
            nxt_dur = WALK_BCD;
         end
         default: begin
            nxt_dur = ALLRED_BCD;
         end
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         phase    <= ALL_RED_B;
         sub      <= SUB_ENTER;
         tmr_load <= 1'b0;
         tmr_hi   <= '0;
         tmr_lo   <= '0;
         light_a  <= LT_RED;
         light_b  <= LT_RED;
         dir      <= 1'b1;
`ifdef TPC_PED_WALK_EN
         walk      <= 1'b0;
         ped_latch <= 1'b0;
`endif
      end else begin
         case (sub)
            // First edge after reset: start with an all-red clearance.
            SUB_ENTER: begin
               sub      <= SUB_LOAD;
               tmr_load <= 1'b1;
               tmr_hi   <= ALLRED_BCD.hi;
               tmr_lo   <= ALLRED_BCD.lo;
            end
            SUB_LOAD: begin
               sub      <= SUB_WAIT;
               tmr_load <= 1'b0;
            end
            SUB_WAIT: begin
               if (tmr_zero) begin
                  phase    <= nxt_phase;
                  sub      <= SUB_LOAD;
                  tmr_load <= 1'b1;
                  tmr_hi   <= nxt_dur.hi;
                  tmr_lo   <= nxt_dur.lo;
                  light_a  <= nxt_la;
                  light_b  <= nxt_lb;
                  dir      <= nxt_dir;
`ifdef TPC_PED_WALK_EN
                  walk     <= (nxt_phase == WALK);
`endif
               end
            end
            default: begin
               sub <= SUB_ENTER;
            end
         endcase
`ifdef TPC_PED_WALK_EN
         // The WALK load cycle consumes the request; a press in that same cycle re-arms it.
         if (sub == SUB_LOAD && phase == WALK) begin
            ped_latch <= ped_req;
         end else if (ped_req) begin
            ped_latch <= 1'b1;
         end
`endif
      end
   end

endmodule
